iter_alu: RTL



---
 rtl/iter_alu.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module   : iter_alu
// Purpose  : Handshaked ALU with single-cycle logic/arith/compare ops and
//            iterative shift-add multiply and restoring unsigned divide/remainder.
// Revision : 1.0
// ============================================================================
module iter_alu #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op_sel,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [3:0] c_OP_AND  = 4'b0000;
   localparam logic [3:0] c_OP_OR   = 4'b0001;
   localparam logic [3:0] c_OP_ADD  = 4'b0010;
   localparam logic [3:0] c_OP_SLT  = 4'b0011;
   localparam logic [3:0] c_OP_SUB  = 4'b0110;
   localparam logic [3:0] c_OP_SLTU = 4'b0111;
   localparam logic [3:0] c_OP_MUL  = 4'b1000;
   localparam logic [3:0] c_OP_DIVU = 4'b1001;
   localparam logic [3:0] c_OP_REMU = 4'b1010;
   localparam logic [3:0] c_OP_NOR  = 4'b1100;

   localparam logic [CNT_W-1:0] c_ITERS = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   logic [WIDTH-1:0] w_alu;
   logic             w_iter;
   logic [WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]   w_trial;
   logic             w_fits;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_final;

   always_comb begin
      w_alu = '0;
      case (op_sel)
         c_OP_AND:  w_alu = src1 & src2;
         c_OP_OR:   w_alu = src1 | src2;
         c_OP_ADD:  w_alu = src1 + src2;
         c_OP_SUB:  w_alu = src1 - src2;
         c_OP_SLTU: w_alu = WIDTH'(src1 < src2);
         c_OP_SLT:  w_alu = WIDTH'($signed(src1) < $signed(src2));
         c_OP_NOR:  w_alu = ~(src1 | src2);
         default:   w_alu = '0;
      endcase
   end

   assign w_iter = (op_sel == c_OP_MUL) || (op_sel == c_OP_DIVU) || (op_sel == c_OP_REMU);

   // Multiply: r_b shifts out MSB-first, r_a is the fixed multiplicand.
   assign w_mul_next = {r_acc[WIDTH-2:0], 1'b0} + (r_b[WIDTH-1] ? r_a : '0);

   // Divide: r_a shifts the dividend out and the quotient in; r_acc is the
   // partial remainder. A zero divisor always "fits", giving all-ones / src1.
   assign w_trial    = {r_acc, r_a[WIDTH-1]} - {1'b0, r_b};
   assign w_fits     = ~w_trial[WIDTH];
   assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
   assign w_quo_next = {r_a[WIDTH-2:0], w_fits};

   always_comb begin
      w_final = w_rem_next;
      case (r_op)
         c_OP_MUL:  w_final = w_mul_next;
         c_OP_DIVU: w_final = w_quo_next;
         default:   w_final = w_rem_next;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op <= op_sel;
                  if (w_iter) begin
                     r_a     <= src1;
                     r_b     <= src2;
                     r_acc   <= '0;
                     r_cnt   <= c_ITERS;
                     r_state <= S_BUSY;
                  end else begin
                     r_result <= w_alu;
                     r_zero   <= (w_alu == '0);
                     r_state  <= S_DONE;
                  end
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - c_LAST;
               if (r_op == c_OP_MUL) begin
                  r_acc <= w_mul_next;
                  r_b   <= r_b << 1;
               end else begin
                  r_acc <= w_rem_next;
                  r_a   <= w_quo_next;
               end
               if (r_cnt == c_LAST) begin
                  r_result <= w_final;
                  r_zero   <= (w_final == '0);
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_BUSY);
   assign result    = r_result;
   assign zero      = r_zero;

endmodule
`default_nettype wire
